// File: rtl/bg_ctrl_pkg.sv
// Shared definitions for the background scene controller.
// Contents:
//   bg_state_t  - controller state encoding (IDLE, FADE_OUT, SWITCH, FADE_IN)
//   SCENE_W     - width of a scene ID
//   SCENE_*     - symbolic scene IDs used by game logic
package bg_ctrl_pkg;

    localparam int SCENE_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } bg_state_t;

    localparam logic [SCENE_W-1:0] SCENE_START_MENU = 4'd0;
    localparam logic [SCENE_W-1:0] SCENE_IN_GAME    = 4'd1;
    localparam logic [SCENE_W-1:0] SCENE_GAME_OVER  = 4'd2;

endpackage

// File: rtl/bg_scene_controller_frame_step_timer.sv
// Frame prescaler: turns frame_start pulses into fade step ticks.
// Ports:
//   Clk, Reset   - clock, synchronous active-high reset
//   clear        - hold the frame counter at 0 (used while idle / waiting to swap)
//   frame_start  - one-cycle pulse at the start of vertical blank
//   step_tick    - combinational: this frame_start completes a fade step
module frame_step_timer
    import bg_ctrl_pkg::*;
#(
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic frame_start,
    output logic step_tick
);

    // Counter is at least 1 bit wide so FRAMES_PER_STEP = 1 still elaborates;
    // in that case it simply stays at 0 and every frame_start is a tick.
    localparam int CW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAMES_PER_STEP - 1);

    logic [CW-1:0] frame_cnt;

    assign step_tick = frame_start && !clear && (frame_cnt == LAST);

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            frame_cnt <= '0;
        end else if (frame_start) begin
            frame_cnt <= (frame_cnt == LAST) ? '0 : frame_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/bg_scene_controller.sv
// Background scene sequencer: accepts a scene-change request, fades to black
// one step per FRAMES_PER_STEP frames, swaps current_bg on a frame boundary
// while black, then fades back in.
// Ports:
//   Clk, Reset   - clock, synchronous active-high reset
//   frame_start  - one-cycle pulse at start of vblank
//   req_valid / req_scene / req_ready - scene-change request handshake
//   req_error    - pulse: accepted request had an out-of-range scene ID
//   current_bg   - scene select to the background ROM mux
//   fade_level   - 0 = full brightness, FADE_STEPS-1 = black
//   busy         - transition in progress
//   switch_done  - pulse when a request has been fully serviced
module bg_scene_controller
    import bg_ctrl_pkg::*;
#(
    parameter int NUM_SCENES      = 3,
    parameter int FADE_STEPS      = 8,
    parameter int FRAMES_PER_STEP = 2,
    parameter int DEFAULT_SCENE   = 0
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_start,
    input  logic                          req_valid,
    input  logic [SCENE_W-1:0]            req_scene,
    output logic                          req_ready,
    output logic                          req_error,
    output logic [SCENE_W-1:0]            current_bg,
    output logic [$clog2(FADE_STEPS)-1:0] fade_level,
    output logic                          busy,
    output logic                          switch_done
);

    localparam int FW = $clog2(FADE_STEPS);
    localparam logic [FW-1:0]      FADE_MAX  = FW'(FADE_STEPS - 1);
    localparam logic [SCENE_W-1:0] SCENE_LIM = SCENE_W'(NUM_SCENES);
    localparam logic [SCENE_W-1:0] SCENE_DEF = SCENE_W'(DEFAULT_SCENE);

    bg_state_t          state;
    logic [SCENE_W-1:0] target;
    logic               step_tick;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // The prescaler only runs while fading; holding it clear in IDLE drops any
    // frame_start that coincides with acceptance, and clearing in SWITCH makes
    // the swap frame the start of a fresh step for the fade-in.
    frame_step_timer #(
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_timer (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      ((state == IDLE) || (state == SWITCH)),
        .frame_start(frame_start),
        .step_tick  (step_tick)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            target      <= SCENE_DEF;
            current_bg  <= SCENE_DEF;
            fade_level  <= '0;
            req_error   <= 1'b0;
            switch_done <= 1'b0;
        end else begin
            req_error   <= 1'b0;
            switch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_scene >= SCENE_LIM) begin
                            req_error <= 1'b1;
                        end else if (req_scene == current_bg) begin
                            switch_done <= 1'b1;
                        end else begin
                            target <= req_scene;
                            state  <= FADE_OUT;
                        end
                    end
                end
                FADE_OUT: begin
                    if (step_tick && fade_level != FADE_MAX) begin
                        fade_level <= fade_level + FW'(1);
                        if (fade_level == FADE_MAX - FW'(1)) state <= SWITCH;
                    end
                end
                SWITCH: begin
                    // Screen is black and we are at vblank: safe to swap.
                    if (frame_start) begin
                        current_bg <= target;
                        state      <= FADE_IN;
                    end
                end
                FADE_IN: begin
                    if (step_tick && fade_level != '0) begin
                        fade_level <= fade_level - FW'(1);
                        if (fade_level == FW'(1)) begin
                            state       <= IDLE;
                            switch_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bg_scene_controller.sv
module tb_bg_scene_controller;

    localparam int FSTEPS = 8;
    localparam int NSC    = 3;

    logic       Clk = 1'b0;
    logic       Reset;
    logic [1:0] fs;
    logic [1:0] rv;
    logic [3:0] rs0, rs1;

    logic       rdy  [2];
    logic       err  [2];
    logic [3:0] bg   [2];
    logic [2:0] lvl  [2];
    logic       bsy  [2];
    logic       done [2];

    always #5 Clk = ~Clk;

    bg_scene_controller dut0 (
        .Clk(Clk), .Reset(Reset), .frame_start(fs[0]), .req_valid(rv[0]), .req_scene(rs0),
        .req_ready(rdy[0]), .req_error(err[0]), .current_bg(bg[0]), .fade_level(lvl[0]),
        .busy(bsy[0]), .switch_done(done[0])
    );

    bg_scene_controller #(.FRAMES_PER_STEP(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .frame_start(fs[1]), .req_valid(rv[1]), .req_scene(rs1),
        .req_ready(rdy[1]), .req_error(err[1]), .current_bg(bg[1]), .fade_level(lvl[1]),
        .busy(bsy[1]), .switch_done(done[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a transition is a count k of frame_starts since
    // acceptance; brightness and scene follow directly from k.
    int fps [2] = '{2, 1};
    int m_bg [2], m_tgt [2], m_k [2];
    bit m_act [2], m_err [2], m_done [2];

    function automatic int n_len(int d);  return 2 * (FSTEPS - 1) * fps[d] + 1; endfunction
    function automatic int sw_pt(int d);  return (FSTEPS - 1) * fps[d] + 1;     endfunction
    function automatic int exp_lvl(int d);
        if (!m_act[d]) return 0;
        if (m_k[d] < sw_pt(d)) return m_k[d] / fps[d];
        return (FSTEPS - 1) - (m_k[d] - sw_pt(d)) / fps[d];
    endfunction

    task automatic model_edge(input int d);
        int s;
        s = (d == 0) ? int'(rs0) : int'(rs1);
        m_err[d] = 0; m_done[d] = 0;
        if (Reset) begin
            m_bg[d] = 0; m_act[d] = 0; m_k[d] = 0;
        end else if (!m_act[d]) begin
            if (rv[d]) begin
                if (s >= NSC)          m_err[d] = 1;
                else if (s == m_bg[d]) m_done[d] = 1;
                else begin m_act[d] = 1; m_k[d] = 0; m_tgt[d] = s; end
            end
        end else if (fs[d]) begin
            m_k[d]++;
            if (m_k[d] >= sw_pt(d)) m_bg[d] = m_tgt[d];
            if (m_k[d] == n_len(d)) begin m_act[d] = 0; m_done[d] = 1; end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int d);
        check($sformatf("d%0d.current_bg", d),  32'(bg[d]),   32'(m_bg[d]));
        check($sformatf("d%0d.fade_level", d),  32'(lvl[d]),  32'(exp_lvl(d)));
        check($sformatf("d%0d.busy", d),        32'(bsy[d]),  32'(m_act[d]));
        check($sformatf("d%0d.req_ready", d),   32'(rdy[d]),  32'(!m_act[d]));
        check($sformatf("d%0d.req_error", d),   32'(err[d]),  32'(m_err[d]));
        check($sformatf("d%0d.switch_done", d), 32'(done[d]), 32'(m_done[d]));
    endtask

    task automatic cycle(input bit r, input bit [1:0] f, input bit [1:0] v,
                         input logic [3:0] s0, input logic [3:0] s1);
        Reset = r; fs = f; rv = v; rs0 = s0; rs1 = s1;
        @(posedge Clk);
        model_edge(0); model_edge(1);
        #1;
        check_all(0); check_all(1);
    endtask

    task automatic request(input int d, input logic [3:0] s, input bit with_fs);
        if (d == 0) cycle(0, {1'b0, with_fs}, 2'b01, s, 4'd0);
        else        cycle(0, {with_fs, 1'b0}, 2'b10, 4'd0, s);
    endtask

    // Random frame_start spacing; optional competing requests mid-transition.
    task automatic run_until_idle(input int d, input bit noise, output int nfs);
        int n = 0;
        bit f, v;
        nfs = 0;
        while (m_act[d] && n < 500) begin
            f = ($urandom_range(0, 1) == 1);
            v = noise && ($urandom_range(0, 3) == 0);
            if (f) nfs++;
            if (d == 0) cycle(0, {1'b0, f}, {1'b0, v}, 4'd2, 4'd0);
            else        cycle(0, {f, 1'b0}, {v, 1'b0}, 4'd0, 4'd2);
            n++;
        end
        check("transition_timeout", 32'(m_act[d]), 32'd0);
    endtask

    initial begin
        int nfs;
        int s;
        for (int d = 0; d < 2; d++) begin
            m_bg[d] = 0; m_tgt[d] = 0; m_k[d] = 0; m_act[d] = 0; m_err[d] = 0; m_done[d] = 0;
        end

        repeat (3) cycle(1, 2'b00, 2'b00, 4'd0, 4'd0);
        // Idle frames do nothing.
        for (int i = 0; i < 20; i++) cycle(0, (i % 2 == 0) ? 2'b11 : 2'b00, 2'b00, 4'd0, 4'd0);

        // Full transition 0 -> 1 with competing scene-2 requests while busy.
        request(0, 4'd1, 1'b0);
        run_until_idle(0, 1'b1, nfs);
        check("len_default", 32'(nfs), 32'd29);
        check("final_scene_1", 32'(bg[0]), 32'd1);
        cycle(0, 2'b00, 2'b00, 4'd0, 4'd0);

        // Same scene -> immediate done; out-of-range -> error.
        request(0, 4'd1, 1'b1);
        cycle(0, 2'b00, 2'b00, 4'd0, 4'd0);
        request(0, 4'd5, 1'b0);
        cycle(0, 2'b00, 2'b00, 4'd0, 4'd0);
        request(0, 4'd15, 1'b0);
        cycle(0, 2'b00, 2'b00, 4'd0, 4'd0);

        // Abort with reset while black and waiting to swap.
        request(0, 4'd0, 1'b0);
        for (int n = 0; n < 500 && m_k[0] < sw_pt(0) - 1; n++)
            cycle(0, {1'b0, 1'($urandom_range(0, 1))}, 2'b00, 4'd0, 4'd0);
        check("at_black", 32'(lvl[0]), 32'd7);
        cycle(1, 2'b01, 2'b01, 4'd2, 4'd0);
        check("reset_bg", 32'(bg[0]), 32'd0);
        request(0, 4'd2, 1'b0);
        run_until_idle(0, 1'b0, nfs);
        check("len_after_reset", 32'(nfs), 32'd29);

        // Random requests on the default-parameter instance.
        repeat (5) begin
            s = $urandom_range(0, 6);
            request(0, 4'(s), 1'($urandom_range(0, 1)));
            run_until_idle(0, 1'b1, nfs);
            repeat (2) cycle(0, 2'b00, 2'b00, 4'd0, 4'd0);
        end

        // One frame per step; request coincides with a frame_start.
        request(1, 4'd2, 1'b1);
        cycle(0, 2'b10, 2'b00, 4'd0, 4'd0);
        check("fps1_first_step", 32'(lvl[1]), 32'd1);
        run_until_idle(1, 1'b1, nfs);
        check("len_fps1", 32'(nfs + 1), 32'd15);
        check("fps1_scene", 32'(bg[1]), 32'd2);
        cycle(0, 2'b00, 2'b00, 4'd0, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
